// File: rtl/ht_head_reader_pkg.sv
// rtl/ht_head_reader_pkg.sv - shared types for the hash-table head-pointer read stage
package hash_table;

    localparam int BUCKET_WIDTH   = 8;
    localparam int HEAD_PTR_WIDTH = 8;

    // Hashed command word as it travels down the hash-table pipeline.
    typedef struct packed {
        logic [3:0]                opcode;
        logic [15:0]               key;
        logic [BUCKET_WIDTH-1:0]   bucket;
        logic [HEAD_PTR_WIDTH-1:0] head_ptr;
        logic                      head_ptr_val;
    } ht_pdata_t;

    // One entry of the per-bucket head-pointer RAM.
    typedef struct packed {
        logic [HEAD_PTR_WIDTH-1:0] ptr;
        logic                      ptr_val;
    } head_ram_data_t;

    // Fold a head RAM return into a command word; every other field passes through.
    function automatic ht_pdata_t merge_head(input ht_pdata_t p, input head_ram_data_t h);
        ht_pdata_t r;
        r              = p;
        r.head_ptr     = h.ptr;
        r.head_ptr_val = h.ptr_val;
        return r;
    endfunction

endpackage

// File: rtl/ht_head_reader_if.sv
// rtl/ht_head_reader_if.sv - command in/out streams and head RAM read port of ht_head_reader
interface ht_head_reader_if;
    import hash_table::*;

    ht_pdata_t                 pdata_in_i;
    logic                      pdata_in_valid_i;
    logic                      pdata_in_ready_o;
    logic [BUCKET_WIDTH-1:0]   rd_addr_o;
    logic                      rd_en_o;
    head_ram_data_t            rd_data_i;
    ht_pdata_t                 pdata_out_o;
    logic                      pdata_out_valid_o;
    logic                      pdata_out_ready_i;

    // Seen from the head reader.
    modport slave (
        input  pdata_in_i, pdata_in_valid_i, rd_data_i, pdata_out_ready_i,
        output pdata_in_ready_o, rd_addr_o, rd_en_o, pdata_out_o, pdata_out_valid_o
    );

    // Seen from the surrounding pipeline / RAM.
    modport master (
        output pdata_in_i, pdata_in_valid_i, rd_data_i, pdata_out_ready_i,
        input  pdata_in_ready_o, rd_addr_o, rd_en_o, pdata_out_o, pdata_out_valid_o
    );

endinterface

// File: rtl/ht_head_reader_sc_fifo.sv
// rtl/ht_head_reader_sc_fifo.sv - single-clock show-ahead FIFO used as the output buffer
module ht_sc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    // Head reads as zero when empty so the output bus is clean out of reset.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the entry is not occupied.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ht_head_reader.sv
// rtl/ht_head_reader.sv - reads the bucket head pointer and merges it into each command word
module ht_head_reader
    import hash_table::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ht_head_reader_if.slave  bus
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PD_W  = $bits(ht_pdata_t);

    logic                  acc;
    logic                  pop;
    logic                  push;
    ht_pdata_t             merged;
    logic [PD_W-1:0]       fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;

    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [RD_LATENCY-1:0] stage_valid_q, stage_valid_d;
    ht_pdata_t             stage_data_q [RD_LATENCY];
    ht_pdata_t             stage_data_d [RD_LATENCY];

    // Credit covers the delay line plus the FIFO, so a word is only accepted
    // when a FIFO slot is guaranteed to be free by the time its RAM data lands.
    // Ready depends on registered occupancy only; a pop frees credit next cycle.
    assign bus.pdata_in_ready_o = (occ_q < OCC_W'(FIFO_DEPTH)) & ~rst_i;
    assign acc                  = bus.pdata_in_valid_i & bus.pdata_in_ready_o;
    assign bus.rd_en_o          = acc;
    assign bus.rd_addr_o        = bus.pdata_in_i.bucket;

    assign push                  = stage_valid_q[RD_LATENCY-1];
    assign pop                   = bus.pdata_out_valid_o & bus.pdata_out_ready_i;
    assign bus.pdata_out_valid_o = ~fifo_empty;
    assign bus.pdata_out_o       = ht_pdata_t'(fifo_head);

    // Delay line, credit counter next-state, and the final-stage merge.
    always_comb begin
        stage_valid_d    = stage_valid_q;
        stage_data_d     = stage_data_q;
        occ_d            = occ_q;
        merged           = merge_head(stage_data_q[RD_LATENCY-1], bus.rd_data_i);

        stage_valid_d[0] = acc;
        if (acc) begin
            stage_data_d[0] = bus.pdata_in_i;
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            stage_valid_d[i] = stage_valid_q[i-1];
            stage_data_d[i]  = stage_data_q[i-1];
        end

        case ({acc, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Pipeline and credit registers; reset discards everything in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q         <= '0;
            stage_valid_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_data_q[i] <= '0;
            end
        end else begin
            occ_q         <= occ_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
        end
    end

    ht_sc_fifo #(
        .WIDTH (PD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (merged),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

`ifndef SYNTHESIS
    // A push into a full FIFO means the credit accounting is broken.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && fifo_full));
        end
    end
`endif

endmodule

// File: tb/tb_ht_head_reader.sv
// tb/tb_ht_head_reader.sv - self-checking bench for ht_head_reader
module tb_ht_head_reader;
    import hash_table::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ht_head_reader_if bus();

    ht_head_reader #(.RD_LATENCY(2), .FIFO_DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic head_ram_data_t ram_word(input logic [7:0] b);
        head_ram_data_t r;
        r.ptr     = b + 8'h10;
        r.ptr_val = b[0];
        return r;
    endfunction

    function automatic ht_pdata_t expect_word(input ht_pdata_t p);
        ht_pdata_t r;
        r              = p;
        r.head_ptr     = p.bucket + 8'h10;
        r.head_ptr_val = p.bucket[0];
        return r;
    endfunction

    // Head RAM model with two clocks of read latency.
    head_ram_data_t ram_d1, ram_d2;
    always @(posedge clk) begin
        ram_d1 <= bus.rd_en_o ? ram_word(bus.rd_addr_o) : '0;
        ram_d2 <= ram_d1;
    end
    assign bus.rd_data_i = ram_d2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted word must come out once, in order, merged.
    ht_pdata_t exp_q[$];
    ht_pdata_t mon_exp;
    int        n_pop = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pdata_in_valid_i && bus.pdata_in_ready_o)
                exp_q.push_back(expect_word(bus.pdata_in_i));
            if (bus.pdata_out_valid_o && bus.pdata_out_ready_i) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 64'(bus.pdata_out_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_word", 64'(bus.pdata_out_o), 64'(mon_exp));
                end
            end
        end
    end

    typedef struct {
        logic [7:0]  bucket;
        logic [15:0] key;
        logic [3:0]  opcode;
        logic [7:0]  exp_ptr;
        logic        exp_val;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int first, last, pops, rdy_low, acc_cnt, nb, sent, cyc, pop_base, vcnt, rdcnt;

        vecs[0] = '{8'h05, 16'h1234, 4'h3, 8'h15, 1'b1};
        vecs[1] = '{8'h00, 16'hBEEF, 4'hA, 8'h10, 1'b0};
        vecs[2] = '{8'hFF, 16'h0001, 4'hF, 8'h0F, 1'b1};
        vecs[3] = '{8'h2A, 16'hCAFE, 4'h0, 8'h3A, 1'b0};
        vecs[4] = '{8'h81, 16'h5A5A, 4'h7, 8'h91, 1'b1};

        rst = 1'b1;
        bus.pdata_in_i        = '0;
        bus.pdata_in_valid_i  = 1'b0;
        bus.pdata_out_ready_i = 1'b0;
        #1;
        check("rst_ready",     64'(bus.pdata_in_ready_o),  0);
        check("rst_out_valid", 64'(bus.pdata_out_valid_o), 0);
        check("rst_rd_en",     64'(bus.rd_en_o),           0);
        check("rst_out_data",  64'(bus.pdata_out_o),       0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.pdata_in_ready_o), 1);
        check("post_rst_occ",   64'(dut.occ_q),            0);

        // Single-word latency and merge for each vector.
        for (int i = 0; i < 5; i++) begin
            bus.pdata_in_i.bucket       = vecs[i].bucket;
            bus.pdata_in_i.key          = vecs[i].key;
            bus.pdata_in_i.opcode       = vecs[i].opcode;
            bus.pdata_in_i.head_ptr     = 8'hEE;
            bus.pdata_in_i.head_ptr_val = 1'b0;
            bus.pdata_in_valid_i        = 1'b1;
            #1;
            check("vec_rd_en",   64'(bus.rd_en_o),   1);
            check("vec_rd_addr", 64'(bus.rd_addr_o), 64'(vecs[i].bucket));
            step();
            bus.pdata_in_valid_i = 1'b0;
            check("vec_valid_n1", 64'(bus.pdata_out_valid_o), 0);
            step();
            check("vec_valid_n2", 64'(bus.pdata_out_valid_o), 0);
            step();
            check("vec_valid_n3", 64'(bus.pdata_out_valid_o), 1);
            check("vec_head_ptr", 64'(bus.pdata_out_o.head_ptr),     64'(vecs[i].exp_ptr));
            check("vec_ptr_val",  64'(bus.pdata_out_o.head_ptr_val), 64'(vecs[i].exp_val));
            check("vec_key",      64'(bus.pdata_out_o.key),          64'(vecs[i].key));
            check("vec_opcode",   64'(bus.pdata_out_o.opcode),       64'(vecs[i].opcode));
            check("vec_bucket",   64'(bus.pdata_out_o.bucket),       64'(vecs[i].bucket));
            bus.pdata_out_ready_i = 1'b1;
            step();
            bus.pdata_out_ready_i = 1'b0;
            check("vec_drained", 64'(bus.pdata_out_valid_o), 0);
            check("vec_occ",     64'(dut.occ_q),             0);
        end

        // Streaming 64 back-to-back words with the sink always ready.
        first = -1; last = -1; pops = 0; rdy_low = 0;
        bus.pdata_out_ready_i = 1'b1;
        for (int c = 0; c < 72; c++) begin
            if (c < 64) begin
                bus.pdata_in_valid_i  = 1'b1;
                bus.pdata_in_i.bucket = 8'(c);
                bus.pdata_in_i.key    = 16'(c * 3);
                bus.pdata_in_i.opcode = 4'(c);
                #1;
                if (!bus.pdata_in_ready_o) rdy_low++;
            end else begin
                bus.pdata_in_valid_i = 1'b0;
                #1;
            end
            if (c == 10) check("stream_occ_steady", 64'(dut.occ_q), 3);
            if (bus.pdata_out_valid_o) begin
                if (first < 0) first = c;
                last = c;
                pops++;
            end
            step();
        end
        check("stream_first",   64'(first),   3);
        check("stream_last",    64'(last),    66);
        check("stream_count",   64'(pops),    64);
        check("stream_rdy_low", 64'(rdy_low), 0);

        // Full backpressure: exactly FIFO_DEPTH accepts, credit returns a cycle after a pop.
        bus.pdata_out_ready_i = 1'b0;
        bus.pdata_in_valid_i  = 1'b1;
        acc_cnt = 0; nb = 0;
        for (int c = 0; c < 10; c++) begin
            bus.pdata_in_i.bucket = 8'(nb);
            #1;
            if (bus.pdata_in_ready_o) begin
                acc_cnt++;
                nb++;
            end
            step();
        end
        check("bp_accepts",    64'(acc_cnt),                4);
        check("bp_ready_low",  64'(bus.pdata_in_ready_o),   0);
        check("bp_head_valid", 64'(bus.pdata_out_valid_o),  1);
        check("bp_head_b0",    64'(bus.pdata_out_o.bucket), 0);
        bus.pdata_out_ready_i = 1'b1;
        #1;
        check("bp_no_comb_credit", 64'(bus.pdata_in_ready_o), 0);
        step();
        bus.pdata_out_ready_i = 1'b0;
        check("bp_ready_back", 64'(bus.pdata_in_ready_o),   1);
        check("bp_head_b1",    64'(bus.pdata_out_o.bucket), 1);
        bus.pdata_in_valid_i  = 1'b0;
        bus.pdata_out_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) step();
        bus.pdata_out_ready_i = 1'b0;
        check("bp_drained", 64'(dut.occ_q), 0);

        // Reset with two words in the delay line and two in the FIFO.
        for (int c = 0; c < 4; c++) begin
            bus.pdata_in_valid_i  = 1'b1;
            bus.pdata_in_i.bucket = 8'(8'h20 + c);
            step();
        end
        bus.pdata_in_valid_i = 1'b0;
        check("mid_occ_full",  64'(dut.occ_q),             4);
        check("mid_out_valid", 64'(bus.pdata_out_valid_o), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid_async", 64'(bus.pdata_out_valid_o), 0);
        check("mid_rst_ready",       64'(bus.pdata_in_ready_o),  0);
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        #1;
        check("mid_post_occ",    64'(dut.occ_q),         0);
        check("mid_post_stages", 64'(dut.stage_valid_q), 0);
        bus.pdata_out_ready_i = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.pdata_out_valid_o) vcnt++;
            step();
        end
        check("mid_no_stale", 64'(vcnt), 0);

        // Input data changing while not valid must not reach the RAM or output.
        vcnt = 0; rdcnt = 0;
        for (int c = 0; c < 8; c++) begin
            bus.pdata_in_i = ht_pdata_t'(64'($urandom));
            #1;
            if (bus.rd_en_o) rdcnt++;
            if (bus.pdata_out_valid_o) vcnt++;
            step();
        end
        check("idle_rd_en",  64'(rdcnt), 0);
        check("idle_output", 64'(vcnt),  0);

        // Random stalls on both sides.
        sent = 0; cyc = 0; pop_base = n_pop;
        while (sent < 2000 && cyc < 30000) begin
            bus.pdata_out_ready_i = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 50) begin
                bus.pdata_in_valid_i        = 1'b1;
                bus.pdata_in_i.bucket       = 8'($urandom);
                bus.pdata_in_i.key          = 16'($urandom);
                bus.pdata_in_i.opcode       = 4'($urandom);
                bus.pdata_in_i.head_ptr     = 8'($urandom);
                bus.pdata_in_i.head_ptr_val = 1'($urandom);
            end else begin
                bus.pdata_in_valid_i = 1'b0;
            end
            #1;
            if (bus.pdata_in_valid_i && bus.pdata_in_ready_o) sent++;
            step();
            cyc++;
        end
        bus.pdata_in_valid_i  = 1'b0;
        bus.pdata_out_ready_i = 1'b1;
        for (int c = 0; c < 50 && (n_pop - pop_base) < 2000; c++) step();
        check("rand_sent",     64'(sent),             2000);
        check("rand_received", 64'(n_pop - pop_base), 2000);
        check("sb_empty",      64'(exp_q.size()),     0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
